// File: rtl/operand_collector_nsrc.sv
`default_nettype none
// ============================================================================
// Module   : operand_collector_nsrc
// Brief    : One collector slot. It holds an issued instruction, gathers its
//            source operands from the register banks or the special-value
//            bypass, and hands the bundle to execute over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module operand_collector_nsrc #(
  parameter int NUM_SRC   = 3,
  parameter int NUM_BANKS = 4,
  parameter int DATA_W    = 256,
  parameter int REG_ID_W  = 5,
  parameter int OCID      = 0,
  parameter int OCID_W    = 4,
  parameter int META_W    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  input  logic [NUM_SRC-1:0]            alloc_src_en,
  input  logic [NUM_SRC*REG_ID_W-1:0]   alloc_reg_id,
  input  logic [NUM_SRC-1:0]            alloc_spe_en,
  input  logic [DATA_W-1:0]             alloc_spe_value,
  input  logic [META_W-1:0]             alloc_meta,
  input  logic [NUM_BANKS*DATA_W-1:0]   bk_data,
  input  logic [NUM_BANKS*OCID_W-1:0]   bk_ocid,
  input  logic [NUM_BANKS-1:0]          bk_vld,
  input  logic [NUM_BANKS-1:0]          bk_bz,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_SRC*DATA_W-1:0]     out_data,
  output logic [NUM_SRC-1:0]            out_src_en,
  output logic [META_W-1:0]             out_meta,
  output logic                          busy
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    READY   = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [NUM_SRC-1:0]            pend_q, pend_d;
  logic [NUM_SRC-1:0]            srcen_q, srcen_d;
  logic [NUM_SRC*REG_ID_W-1:0]   regid_q, regid_d;
  logic [NUM_SRC*DATA_W-1:0]     data_q, data_d;
  logic [META_W-1:0]             meta_q, meta_d;

  logic [NUM_SRC-1:0]            w_cap;
  logic [NUM_SRC*DATA_W-1:0]     w_cap_data;
  logic [NUM_SRC-1:0]            w_ld_pend;
  logic [NUM_SRC*DATA_W-1:0]     w_ld_data;
  logic                          w_fire;
  logic                          w_unused_regid;

  // Each source only listens to its own bank, and only for its own tag.
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    localparam logic [OCID_W-1:0] C_TAG = OCID_W'(OCID * NUM_SRC + s);
    logic [BANK_W-1:0] w_bank;
    if (NUM_BANKS > 1) begin : g_multi
      assign w_bank = regid_q[s*REG_ID_W + REG_ID_W - 1 -: BANK_W];
    end else begin : g_single
      assign w_bank = '0;
    end
    assign w_cap[s] = pend_q[s] && bk_vld[w_bank] && !bk_bz[w_bank] &&
                      (bk_ocid[w_bank*OCID_W +: OCID_W] == C_TAG);
    assign w_cap_data[s*DATA_W +: DATA_W] = bk_data[w_bank*DATA_W +: DATA_W];
  end

  assign w_unused_regid = ^regid_q;

  assign alloc_ready = !rst && (state_q == IDLE || (state_q == READY && out_ready));
  assign w_fire      = alloc_valid && alloc_ready;

  always_comb begin
    w_ld_pend = '0;
    w_ld_data = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (alloc_src_en[s]) begin
        if (alloc_spe_en[s]) w_ld_data[s*DATA_W +: DATA_W] = alloc_spe_value;
        else                 w_ld_pend[s] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    srcen_d = srcen_q;
    regid_d = regid_q;
    data_d  = data_q;
    meta_d  = meta_q;
    unique case (state_q)
      COLLECT: begin
        for (int s = 0; s < NUM_SRC; s++) begin
          if (w_cap[s]) data_d[s*DATA_W +: DATA_W] = w_cap_data[s*DATA_W +: DATA_W];
        end
        pend_d = pend_q & ~w_cap;
        if ((pend_q & ~w_cap) == '0) state_d = READY;
      end
      READY: begin
        if (out_ready) begin
          state_d = IDLE;
          pend_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A fire in READY overrides the dispatch, giving back-to-back issue.
    if (w_fire) begin
      pend_d  = w_ld_pend;
      data_d  = w_ld_data;
      srcen_d = alloc_src_en;
      regid_d = alloc_reg_id;
      meta_d  = alloc_meta;
      state_d = (|w_ld_pend) ? COLLECT : READY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      srcen_q <= '0;
      regid_q <= '0;
      data_q  <= '0;
      meta_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      srcen_q <= srcen_d;
      regid_q <= regid_d;
      data_q  <= data_d;
      meta_q  <= meta_d;
    end
  end

  assign out_valid  = (state_q == READY);
  assign busy       = (state_q != IDLE);
  assign out_data   = data_q;
  assign out_src_en = srcen_q;
  assign out_meta   = meta_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_collector_nsrc.sv
`default_nettype none
// Bench for operand_collector_nsrc (OCID=1, 3 sources, 4 banks): directed
// vectors and sequences plus random traffic against a transaction-level model.
module tb_operand_collector_nsrc;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid;
  logic          alloc_ready;
  logic [2:0]    alloc_src_en;
  logic [14:0]   alloc_reg_id;
  logic [2:0]    alloc_spe_en;
  logic [255:0]  alloc_spe_value;
  logic [63:0]   alloc_meta;
  logic [1023:0] bk_data;
  logic [15:0]   bk_ocid;
  logic [3:0]    bk_vld;
  logic [3:0]    bk_bz;
  logic          out_valid;
  logic          out_ready;
  logic [767:0]  out_data;
  logic [2:0]    out_src_en;
  logic [63:0]   out_meta;
  logic          busy;

  int errors = 0;
  int checks = 0;

  operand_collector_nsrc #(
    .NUM_SRC(3), .NUM_BANKS(4), .DATA_W(256), .REG_ID_W(5),
    .OCID(1), .OCID_W(4), .META_W(64)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_src_en(alloc_src_en), .alloc_reg_id(alloc_reg_id),
    .alloc_spe_en(alloc_spe_en), .alloc_spe_value(alloc_spe_value),
    .alloc_meta(alloc_meta),
    .bk_data(bk_data), .bk_ocid(bk_ocid), .bk_vld(bk_vld), .bk_bz(bk_bz),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src_en(out_src_en), .out_meta(out_meta), .busy(busy)
  );

  always #5 clk = ~clk;

  // Transaction-level model: an instruction is held, each source still
  // "needs" an operand or not, and it is valid once nothing is needed.
  bit           m_have;
  bit           m_rst;
  logic [2:0]   m_need;
  logic [255:0] m_data [3];
  logic [4:0]   m_reg  [3];
  logic [63:0]  m_meta;
  logic [2:0]   m_srcen;

  task automatic chk1(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, a, e);
    end
  endtask

  task automatic chkw(input string nm, input logic [767:0] a, input logic [767:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, a, e);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_edge(input bit rdy);
    bit vpre;
    vpre = m_have && (m_need == 3'b000);
    if (rst) begin
      m_have = 0; m_rst = 1; m_need = 0; m_meta = 0; m_srcen = 0;
      for (int s = 0; s < 3; s++) m_data[s] = '0;
    end else begin
      if (m_have && !vpre) begin
        for (int s = 0; s < 3; s++) begin
          int b;
          b = int'(m_reg[s]) / 8;
          if (m_need[s] && bk_vld[b] && !bk_bz[b] && bk_ocid[b*4 +: 4] == 4'(3 + s)) begin
            m_data[s] = bk_data[b*256 +: 256];
            m_need[s] = 1'b0;
          end
        end
      end
      if (vpre && out_ready) m_have = 0;
      if (alloc_valid && rdy) begin
        m_have = 1; m_rst = 0;
        m_meta = alloc_meta; m_srcen = alloc_src_en;
        for (int s = 0; s < 3; s++) begin
          m_reg[s]  = alloc_reg_id[s*5 +: 5];
          m_need[s] = alloc_src_en[s] && !alloc_spe_en[s];
          m_data[s] = (alloc_src_en[s] && alloc_spe_en[s]) ? alloc_spe_value : '0;
        end
      end
    end
  endtask

  // One clock: check alloc_ready before the edge, advance model, check outputs.
  task automatic step();
    bit rdy;
    #1;
    rdy = !rst && (!m_have || (m_have && m_need == 3'b000 && out_ready));
    chk1("alloc_ready", alloc_ready, rdy);
    @(posedge clk);
    model_edge(rdy);
    #1;
    chk1("out_valid", out_valid, m_have && m_need == 3'b000);
    chk1("busy", busy, m_have);
    if (m_have || m_rst) begin
      chkw("out_data", out_data, {m_data[2], m_data[1], m_data[0]});
      chkw("out_meta", 768'(out_meta), 768'(m_meta));
      chkw("out_src_en", 768'(out_src_en), 768'(m_srcen));
    end
  endtask

  task automatic clr();
    rst = 0; alloc_valid = 0; alloc_src_en = 0; alloc_spe_en = 0;
    bk_vld = 0; bk_bz = 0; out_ready = 0;
  endtask

  task automatic bank(input int b, input int tag, input logic [255:0] d);
    bk_vld[b] = 1'b1;
    bk_ocid[b*4 +: 4] = 4'(tag);
    bk_data[b*256 +: 256] = d;
  endtask

  task automatic do_reset();
    clr(); rst = 1; step(); rst = 0;
  endtask

  typedef struct {
    logic [2:0] src_en;
    logic [2:0] spe_en;
    logic [7:0] spe_b;
    bit         exp_valid;
    logic [2:0] exp_spe_slots;
  } vec_t;

  vec_t vecs [7];
  logic [255:0] AA, BB;
  logic [767:0] e;

  initial begin
    vecs[0] = '{3'b000, 3'b000, 8'h11, 1'b1, 3'b000};
    vecs[1] = '{3'b111, 3'b111, 8'h5A, 1'b1, 3'b111};
    vecs[2] = '{3'b101, 3'b101, 8'h3C, 1'b1, 3'b101};
    vecs[3] = '{3'b010, 3'b111, 8'h77, 1'b1, 3'b010};
    vecs[4] = '{3'b111, 3'b101, 8'h5A, 1'b0, 3'b101};
    vecs[5] = '{3'b011, 3'b000, 8'hFF, 1'b0, 3'b000};
    vecs[6] = '{3'b100, 3'b000, 8'h00, 1'b0, 3'b000};
    AA = {32{8'hAA}};
    BB = {32{8'hBB}};
    m_have = 0; m_rst = 0; m_need = 0; m_meta = 0; m_srcen = 0;
    for (int s = 0; s < 3; s++) begin m_data[s] = '0; m_reg[s] = '0; end
    alloc_reg_id = 0; alloc_spe_value = 0; alloc_meta = 0;
    bk_data = 0; bk_ocid = 0;
    clr();

    // Allocation-only vectors: one-cycle latency when nothing is pending.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      alloc_valid = 1; alloc_src_en = vecs[i].src_en; alloc_spe_en = vecs[i].spe_en;
      alloc_spe_value = {32{vecs[i].spe_b}}; alloc_reg_id = 15'($urandom);
      alloc_meta = {$urandom, $urandom};
      step();
      alloc_valid = 0;
      e = '0;
      for (int s = 0; s < 3; s++)
        if (vecs[i].exp_spe_slots[s]) e[s*256 +: 256] = {32{vecs[i].spe_b}};
      chk1("vec_valid", out_valid, vecs[i].exp_valid);
      chkw("vec_data", out_data, e);
    end

    // Bank gather, with a response on the allocation edge that must be missed.
    do_reset();
    alloc_valid = 1; alloc_src_en = 3'b011; alloc_spe_en = 0;
    alloc_reg_id = {5'd0, 5'd26, 5'd9}; alloc_meta = 64'h1234_5678_9ABC_DEF0;
    bank(3, 4, {32{8'hCC}});
    step();
    clr();
    chkw("alloc_edge_slot1", 768'(out_data[511:256]), 768'(0));
    step(); step(); step();
    bank(3, 4, BB); step(); clr();
    chk1("valid_after_first", out_valid, 1'b0);
    step();
    bank(1, 3, AA); step(); clr();
    chk1("valid_after_last", out_valid, 1'b1);
    chkw("gather_data", out_data, {256'h0, BB, AA});

    // Filtering: busy bank, wrong bank, repeat response to a captured source.
    do_reset();
    alloc_valid = 1; alloc_src_en = 3'b011; alloc_reg_id = {5'd0, 5'd26, 5'd9};
    step(); clr();
    bank(1, 3, {32{8'h11}}); bk_bz[1] = 1; step(); clr();
    bank(2, 3, {32{8'h22}}); bank(0, 4, {32{8'h33}}); step(); clr();
    chkw("filter_data", out_data, 768'(0));
    bank(1, 3, AA); step(); clr();
    bank(1, 3, {32{8'hEE}}); step(); clr();
    chkw("no_recapture", out_data, {256'h0, 256'h0, AA});
    bank(3, 4, BB); step(); clr();
    chk1("filter_valid", out_valid, 1'b1);

    // Back-pressure in READY, then back-to-back allocation.
    for (int i = 0; i < 4; i++) begin
      bank(3, 4, {32{8'h44}}); step(); clr();
      chkw("hold_data", out_data, {256'h0, BB, AA});
    end
    out_ready = 1; alloc_valid = 1; alloc_src_en = 3'b000; alloc_meta = 64'hFEED;
    step(); clr();
    chk1("b2b_busy", busy, 1'b1);
    chkw("b2b_meta", 768'(out_meta), 768'(64'hFEED));
    out_ready = 1; step(); clr();
    chk1("dispatch_busy", busy, 1'b0);

    // Reset mid-COLLECT with a simultaneous response.
    alloc_valid = 1; alloc_src_en = 3'b001; alloc_reg_id = 15'd9; step(); clr();
    rst = 1; bank(1, 3, AA); step(); step(); clr();
    chk1("rst_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chkw("rst_data", out_data, 768'(0));
    #1 chk1("rdy_after_rst", alloc_ready, 1'b1);
    step();

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      alloc_valid = 1'($urandom);
      alloc_src_en = 3'($urandom); alloc_spe_en = 3'($urandom);
      alloc_reg_id = 15'($urandom); alloc_spe_value = rnd256();
      alloc_meta = {$urandom, $urandom};
      for (int b = 0; b < 4; b++) begin
        bk_vld[b] = 1'($urandom);
        bk_bz[b] = ($urandom_range(0, 4) == 0);
        bk_ocid[b*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(3 + $urandom_range(0, 2));
        bk_data[b*256 +: 256] = rnd256();
      end
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
